// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle control FSM: sequences FETCH/DECODE/EXEC/MEM/WB and drives
// the datapath select codes and write enables from state + opcode/funct.
module multi_cycle_ctrl #(
  parameter bit USE_MEM_READY = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] npc_sel,
  output logic [1:0] npcimm_muxop,
  output logic [1:0] grfa3_muxop,
  output logic [1:0] grfwd_muxop,
  output logic       alub_muxop,
  output logic [2:0] alu_op,
  output logic [1:0] ext_op,
  output logic       grf_we,
  output logic       dm_we,
  output logic       illegal,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    I_NOP, I_ILL, I_J, I_JAL, I_JR, I_ADDU, I_SUBU,
    I_ORI, I_LW, I_SW, I_BEQ, I_LUI
  } inst_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b010;

  state_t cur, nxt;
  inst_t  inst;
  logic   mem_done;

  assign mem_done = USE_MEM_READY ? mem_ready : 1'b1;
  assign state    = cur;

  always_comb begin
    inst = I_ILL;
    case (opcode)
      6'h00: begin
        case (funct)
          6'h00:   inst = I_NOP;
          6'h08:   inst = I_JR;
          6'h21:   inst = I_ADDU;
          6'h23:   inst = I_SUBU;
          default: inst = I_ILL;
        endcase
      end
      6'h02:   inst = I_J;
      6'h03:   inst = I_JAL;
      6'h04:   inst = I_BEQ;
      6'h0d:   inst = I_ORI;
      6'h0f:   inst = I_LUI;
      6'h23:   inst = I_LW;
      6'h2b:   inst = I_SW;
      default: inst = I_ILL;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cur <= S_FETCH;
    else          cur <= nxt;
  end

  always_comb begin
    nxt          = S_FETCH;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    npc_sel      = 2'b00;
    npcimm_muxop = 2'b00;
    grfa3_muxop  = 2'b00;
    grfwd_muxop  = 2'b00;
    alub_muxop   = 1'b0;
    alu_op       = ALU_ADD;
    ext_op       = 2'b00;
    grf_we       = 1'b0;
    dm_we        = 1'b0;
    illegal      = 1'b0;
    case (cur)
      S_FETCH: begin
        ir_we = 1'b1;
        nxt   = S_DECODE;
      end
      S_DECODE: begin
        case (inst)
          I_J: begin
            pc_we = 1'b1; npc_sel = 2'b10; npcimm_muxop = 2'b01;
          end
          I_JAL: begin
            pc_we = 1'b1; npc_sel = 2'b10; npcimm_muxop = 2'b01;
            grf_we = 1'b1; grfa3_muxop = 2'b10; grfwd_muxop = 2'b11;
          end
          I_JR: begin
            pc_we = 1'b1; npc_sel = 2'b10; npcimm_muxop = 2'b10;
          end
          I_NOP: pc_we = 1'b1;
          I_ILL: begin
            pc_we = 1'b1; illegal = 1'b1;
          end
          I_LUI:   nxt = S_WB;
          default: nxt = S_EXEC;
        endcase
      end
      S_EXEC: begin
        case (inst)
          I_ADDU: begin alub_muxop = 1'b1; alu_op = ALU_ADD; nxt = S_WB; end
          I_SUBU: begin alub_muxop = 1'b1; alu_op = ALU_SUB; nxt = S_WB; end
          I_ORI:  begin alu_op = ALU_OR; nxt = S_WB; end
          I_LW, I_SW: begin ext_op = 2'b01; nxt = S_MEM; end
          I_BEQ: begin
            alub_muxop = 1'b1; alu_op = ALU_SUB; ext_op = 2'b01;
            pc_we = 1'b1; npc_sel = zero ? 2'b01 : 2'b00;
          end
          default: nxt = S_FETCH;
        endcase
      end
      S_MEM: begin
        // address computation stays on the ALU for the whole access
        ext_op = 2'b01;
        case (inst)
          I_SW: begin
            dm_we = 1'b1;
            if (mem_done) pc_we = 1'b1;
            else          nxt   = S_MEM;
          end
          I_LW:    nxt = mem_done ? S_WB : S_MEM;
          default: nxt = S_FETCH;
        endcase
      end
      S_WB: begin
        case (inst)
          I_ADDU, I_SUBU: begin
            grf_we = 1'b1; pc_we = 1'b1; grfa3_muxop = 2'b01;
            alub_muxop = 1'b1; alu_op = (inst == I_SUBU) ? ALU_SUB : ALU_ADD;
          end
          I_ORI: begin grf_we = 1'b1; pc_we = 1'b1; alu_op = ALU_OR; end
          I_LW:  begin grf_we = 1'b1; pc_we = 1'b1; grfwd_muxop = 2'b01; end
          I_LUI: begin
            grf_we = 1'b1; pc_we = 1'b1; grfwd_muxop = 2'b10; ext_op = 2'b10;
          end
          default: ;
        endcase
      end
      default: nxt = S_FETCH;
    endcase
    // everything quiet while reset is held, including FETCH's ir_we
    if (!reset_n) begin
      ir_we = 1'b0; pc_we = 1'b0; npc_sel = 2'b00; npcimm_muxop = 2'b00;
      grfa3_muxop = 2'b00; grfwd_muxop = 2'b00; alub_muxop = 1'b0;
      alu_op = ALU_ADD; ext_op = 2'b00; grf_we = 1'b0; dm_we = 1'b0;
      illegal = 1'b0;
    end
  end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Scoreboard bench for multi_cycle_ctrl: stimulus pushes expected per-cycle
// control vectors; a negedge monitor pops and compares them.
module tb_multi_cycle_ctrl;

  typedef struct packed {
    logic [2:0] st;
    logic       ir, pc;
    logic [1:0] npc, nim, a3, wd;
    logic       alub;
    logic [2:0] alu;
    logic [1:0] ext;
    logic       grf, dm, ill;
  } exp_t;

  typedef struct {
    string name;
    exp_t  v;
  } item_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [5:0] opcode = '0, funct = '0;
  logic zero = 1'b0, mem_ready = 1'b0;
  logic ir_we, pc_we, alub_muxop, grf_we, dm_we, illegal;
  logic [1:0] npc_sel, npcimm_muxop, grfa3_muxop, grfwd_muxop, ext_op;
  logic [2:0] alu_op, state;

  item_t q[$];
  int checks = 0, errors = 0;

  multi_cycle_ctrl #(.USE_MEM_READY(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .funct(funct),
    .zero(zero), .mem_ready(mem_ready), .ir_we(ir_we), .pc_we(pc_we),
    .npc_sel(npc_sel), .npcimm_muxop(npcimm_muxop), .grfa3_muxop(grfa3_muxop),
    .grfwd_muxop(grfwd_muxop), .alub_muxop(alub_muxop), .alu_op(alu_op),
    .ext_op(ext_op), .grf_we(grf_we), .dm_we(dm_we), .illegal(illegal),
    .state(state)
  );

  always #5 clk = ~clk;

  function automatic exp_t ex(input logic [2:0] st, input logic ir, pc,
                              input logic [1:0] npc, nim, a3, wd,
                              input logic alub, input logic [2:0] alu,
                              input logic [1:0] ext, input logic grf, dm, ill);
    exp_t e;
    e = '{st, ir, pc, npc, nim, a3, wd, alub, alu, ext, grf, dm, ill};
    return e;
  endfunction

  // monitor: the DUT presents a control vector every cycle
  always @(negedge clk) begin
    if (q.size() > 0) begin
      item_t it;
      exp_t  act;
      it  = q.pop_front();
      act = '{state, ir_we, pc_we, npc_sel, npcimm_muxop, grfa3_muxop,
              grfwd_muxop, alub_muxop, alu_op, ext_op, grf_we, dm_we, illegal};
      checks++;
      if (act !== it.v) begin
        errors++;
        $display("FAIL %s: got %h expected %h", it.name, act, it.v);
      end
    end
  end

  task automatic step(input string n, input exp_t e);
    item_t it;
    it.name = n;
    it.v    = e;
    q.push_back(it);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_decode(input string n, input logic [5:0] op, fn);
    opcode = op; funct = fn;
    step({n, "_fetch"},  ex(0,1,0,0,0,0,0,0,0,0,0,0,0));
    step({n, "_decode"}, ex(1,0,0,0,0,0,0,0,0,0,0,0,0));
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk); #1;
    step("reset_hold", ex(0,0,0,0,0,0,0,0,0,0,0,0,0));
    reset_n = 1'b1;

    // addu abandoned by async reset in EXEC
    fetch_decode("addu_a", 6'h00, 6'h21);
    reset_n = 1'b0;
    step("async_rst", ex(0,0,0,0,0,0,0,0,0,0,0,0,0));
    reset_n = 1'b1;

    // full addu
    fetch_decode("addu", 6'h00, 6'h21);
    step("addu_exec", ex(2,0,0,0,0,0,0,1,0,0,0,0,0));
    step("addu_wb",   ex(4,0,1,0,0,1,0,1,0,0,1,0,0));

    // subu
    fetch_decode("subu", 6'h00, 6'h23);
    step("subu_exec", ex(2,0,0,0,0,0,0,1,1,0,0,0,0));
    step("subu_wb",   ex(4,0,1,0,0,1,0,1,1,0,1,0,0));

    // ori
    fetch_decode("ori", 6'h0d, 6'h00);
    step("ori_exec", ex(2,0,0,0,0,0,0,0,2,0,0,0,0));
    step("ori_wb",   ex(4,0,1,0,0,0,0,0,2,0,1,0,0));

    // lw with mem_ready high outside MEM, then low three MEM cycles
    mem_ready = 1'b1;
    fetch_decode("lw", 6'h23, 6'h00);
    step("lw_exec", ex(2,0,0,0,0,0,0,0,0,1,0,0,0));
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) step("lw_mem_wait", ex(3,0,0,0,0,0,0,0,0,1,0,0,0));
    mem_ready = 1'b1;
    step("lw_mem_done", ex(3,0,0,0,0,0,0,0,0,1,0,0,0));
    step("lw_wb",       ex(4,0,1,0,0,0,1,0,0,0,1,0,0));

    // sw one wait cycle, then sw immediate
    fetch_decode("sw_w", 6'h2b, 6'h00);
    step("sw_w_exec", ex(2,0,0,0,0,0,0,0,0,1,0,0,0));
    mem_ready = 1'b0;
    step("sw_w_mem_wait", ex(3,0,0,0,0,0,0,0,0,1,0,1,0));
    mem_ready = 1'b1;
    step("sw_w_mem_done", ex(3,0,1,0,0,0,0,0,0,1,0,1,0));
    fetch_decode("sw", 6'h2b, 6'h00);
    step("sw_exec", ex(2,0,0,0,0,0,0,0,0,1,0,0,0));
    step("sw_mem",  ex(3,0,1,0,0,0,0,0,0,1,0,1,0));

    // beq taken / not taken
    zero = 1'b1;
    fetch_decode("beq_t", 6'h04, 6'h00);
    step("beq_t_exec", ex(2,0,1,1,0,0,0,1,1,1,0,0,0));
    zero = 1'b0;
    fetch_decode("beq_n", 6'h04, 6'h00);
    step("beq_n_exec", ex(2,0,1,0,0,0,0,1,1,1,0,0,0));

    // lui skips EXEC
    fetch_decode("lui", 6'h0f, 6'h00);
    step("lui_wb", ex(4,0,1,0,0,0,2,0,0,2,1,0,0));

    // two-cycle instructions retire in DECODE
    opcode = 6'h03; funct = 6'h00;
    step("jal_fetch",  ex(0,1,0,0,0,0,0,0,0,0,0,0,0));
    step("jal_decode", ex(1,0,1,2,1,2,3,0,0,0,1,0,0));
    opcode = 6'h02;
    step("j_fetch",    ex(0,1,0,0,0,0,0,0,0,0,0,0,0));
    step("j_decode",   ex(1,0,1,2,1,0,0,0,0,0,0,0,0));
    opcode = 6'h00; funct = 6'h08;
    step("jr_fetch",   ex(0,1,0,0,0,0,0,0,0,0,0,0,0));
    step("jr_decode",  ex(1,0,1,2,2,0,0,0,0,0,0,0,0));
    funct = 6'h00;
    step("nop_fetch",  ex(0,1,0,0,0,0,0,0,0,0,0,0,0));
    step("nop_decode", ex(1,0,1,0,0,0,0,0,0,0,0,0,0));
    opcode = 6'h3f;
    step("ill_fetch",  ex(0,1,0,0,0,0,0,0,0,0,0,0,0));
    step("ill_decode", ex(1,0,1,0,0,0,0,0,0,0,0,0,1));
    opcode = 6'h00; funct = 6'h20;
    step("illf_fetch",  ex(0,1,0,0,0,0,0,0,0,0,0,0,0));
    step("illf_decode", ex(1,0,1,0,0,0,0,0,0,0,0,0,1));
    step("final_fetch", ex(0,1,0,0,0,0,0,0,0,0,0,0,0));

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
